// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the display write arbiter.
//   state_e        - arbiter FSM states (IDLE, ACK)
//   NUM_REQ        - number of write requesters (0 = CPU MMIO, 1 = debug monitor)
//   NUM_DISP_REGS  - number of display byte registers
//   NUM_DIGITS     - number of 7-segment digits (two per display byte)
//   ADDR_MASK      - write address that targets the blink mask register
//   pick_winner()  - arbitration rule: single requester wins, round-robin on a tie
package display_pkg;

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  localparam int unsigned NUM_REQ       = 2;
  localparam int unsigned NUM_DISP_REGS = 3;
  localparam int unsigned NUM_DIGITS    = 2 * NUM_DISP_REGS;
  localparam logic [1:0]  ADDR_MASK     = 2'd3;

  // Index of the requester granted this cycle. Only meaningful when any valid bit is set.
  function automatic logic pick_winner(input logic [NUM_REQ-1:0] valid, input logic rr);
    if (valid == 2'b11) begin
      return rr;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/display_blink_timer.sv
// display_blink_timer: free-running blink phase generator.
//   BLINK_DIV  - phase half-period in clock cycles (>= 2)
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset (counter and phase cleared)
//   phase      - blink phase; toggles every BLINK_DIV cycles
module display_blink_timer #(
  parameter logic [23:0] BLINK_DIV = 24'd12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  logic [23:0] cnt_q;
  logic        phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 24'd0;
      phase_q <= 1'b0;
    end else if (cnt_q == BLINK_DIV - 24'd1) begin
      cnt_q   <= 24'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: two-requester write arbiter for the display register file.
// Each accepted write takes one IDLE (grant) cycle and one ACK cycle, so at
// most one write completes every two cycles. Ties are broken by a round-robin
// pointer that always moves to the loser, so a waiting requester is served next.
//
// Optional feature: define DISPLAY_BLINK_EN to add the blink mask register and
// the blink timer. Without it, address-3 writes are acknowledged but dropped and
// o_blank is tied low.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_valid  - per-requester write request (0 = CPU MMIO, 1 = debug monitor)
//   i_addr   - per-requester target: 0..2 display byte, 3 blink mask
//   i_data   - per-requester write data
//   o_ready  - one-cycle write acknowledge (at most one bit set)
//   o_regs   - display byte registers for the 7-segment decoder bank
//   o_blank  - per-digit blank; bit 2k = low nibble of o_regs[k], 2k+1 = high nibble
//   o_busy   - high during the ACK cycle
module display_arbiter
  import display_pkg::*;
#(
  parameter logic [23:0] BLINK_DIV = 24'd12_500_000
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_REQ-1:0]                  i_valid,
  input  logic [NUM_REQ-1:0][1:0]             i_addr,
  input  logic [NUM_REQ-1:0][7:0]             i_data,
  output logic [NUM_REQ-1:0]                  o_ready,
  output logic [NUM_DISP_REGS-1:0][7:0]       o_regs,
  output logic [NUM_DIGITS-1:0]               o_blank,
  output logic                                o_busy
);

  state_e                          state_q;
  logic                            rr_q;
  logic [NUM_DISP_REGS-1:0][7:0]   regs_q;
  logic [NUM_REQ-1:0]              ready_q;
  logic                            busy_q;

  logic                            winner;
  logic [1:0]                      win_addr;
  logic [7:0]                      win_data;

  // Winner and its payload are resolved combinationally from the held request
  // and captured on the grant edge; inputs seen during ACK are ignored.
  always_comb begin
    winner   = pick_winner(i_valid, rr_q);
    win_addr = i_addr[winner];
    win_data = i_data[winner];
  end

`ifdef DISPLAY_BLINK_EN
  logic [NUM_DIGITS-1:0] mask_q;
  logic                  phase;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      regs_q  <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
`ifdef DISPLAY_BLINK_EN
      mask_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|i_valid) begin
            ready_q <= 2'b01 << winner;
            busy_q  <= 1'b1;
            rr_q    <= ~winner;
            state_q <= ACK;
            if (win_addr == ADDR_MASK) begin
`ifdef DISPLAY_BLINK_EN
              mask_q <= win_data[NUM_DIGITS-1:0];
`endif
            end else begin
              regs_q[win_addr] <= win_data;
            end
          end
        end
        ACK: begin
          ready_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DISPLAY_BLINK_EN
  display_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .phase (phase)
  );

  assign o_blank = mask_q & {NUM_DIGITS{phase}};
`else
  // Blink period only matters when the timer is built in.
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;

  assign o_blank = '0;
`endif

  assign o_ready = ready_q;
  assign o_regs  = regs_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: self-checking bench for display_arbiter.
// A stimulus process drives held requests and, from a transaction-level model
// of the arbitration rules, pushes the expected acknowledge into a queue; a
// negedge monitor pops and compares whenever the DUT acknowledges.
module tb_display_arbiter;

  localparam logic [23:0] BLINK_DIV = 24'd4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      valid;
  logic [1:0][1:0] addr;
  logic [1:0][7:0] data;
  logic [1:0]      ready;
  logic [2:0][7:0] regs;
  logic [5:0]      blank;
  logic            busy;

  display_arbiter #(
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_addr  (addr),
    .i_data  (data),
    .o_ready (ready),
    .o_regs  (regs),
    .o_blank (blank),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      rdy;
    logic [2:0][7:0] regs;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int g1_cnt = 0;

  // Requester-side view: a pending request is held until the model grants it.
  bit         pend [2];
  logic [1:0] s_addr [2];
  logic [7:0] s_data [2];

  // Reference model state.
  bit              m_ack;
  int              m_rr;
  logic [2:0][7:0] m_regs;
  logic [5:0]      m_mask;
  int              m_edges;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_blank();
`ifdef DISPLAY_BLINK_EN
    if (((m_edges / int'(BLINK_DIV)) % 2) == 1) return m_mask;
    return 6'h00;
`else
    return 6'h00;
`endif
  endfunction

  task automatic model_reset();
    m_ack   = 1'b0;
    m_rr    = 0;
    m_regs  = '0;
    m_mask  = '0;
    m_edges = 0;
    exp_q.delete();
  endtask

  // One rising edge as seen by the model, using the request currently presented.
  task automatic model_edge();
    int   w;
    exp_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_edges++;
    if (m_ack) begin
      m_ack = 1'b0;
    end else if (valid != 2'b00) begin
      if (valid == 2'b11) w = m_rr;
      else w = valid[1] ? 1 : 0;
      m_rr = 1 - w;
      if (addr[w] == 2'd3) begin
`ifdef DISPLAY_BLINK_EN
        m_mask = data[w][5:0];
`endif
      end else begin
        m_regs[addr[w]] = data[w];
      end
      pend[w] = 1'b0;
      e.rdy = 2'b00;
      e.rdy[w] = 1'b1;
      e.regs = m_regs;
      exp_q.push_back(e);
      m_ack = 1'b1;
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      valid[r] = pend[r];
      addr[r]  = s_addr[r];
      data[r]  = s_data[r];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  task automatic set_req(input int r, input logic [1:0] a, input logic [7:0] d);
    pend[r]   = 1'b1;
    s_addr[r] = a;
    s_data[r] = d;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy", busy, m_ack);
      check("regs", regs, m_regs);
      check("blank", blank, exp_blank());
      if (ready != 2'b00 || m_ack) begin
        if (exp_q.size() == 0) begin
          check("ready_unexpected", ready, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ready", ready, e.rdy);
        end
      end
      if (ready[1]) g1_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    s_addr[0] = '0; s_addr[1] = '0;
    s_data[0] = '0; s_data[1] = '0;
    drive();
    model_reset();
    repeat (3) tick();
    check("reset_ready", ready, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_regs", regs, 24'h0);
    check("reset_blank", blank, 6'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write from requester 0.
    set_req(0, 2'd1, 8'hA5);
    drive();
    tick();
    check("single_ready", ready, 2'b01);
    check("single_reg1", regs[1], 8'hA5);
    check("single_busy", busy, 1'b1);
    tick();
    check("single_busy_drop", busy, 1'b0);
    repeat (2) tick();

    // Contention from reset: requester 0 first, then 1.
    do_reset();
    set_req(0, 2'd0, 8'h11);
    set_req(1, 2'd0, 8'h22);
    drive();
    tick();
    check("tie_first", ready, 2'b01);
    repeat (2) tick();
    check("tie_second", ready, 2'b10);
    tick();
    check("tie_final_reg0", regs[0], 8'h22);

    // Continuous contention: grants must alternate.
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r]) set_req(r, 2'($urandom_range(0, 2)), 8'($urandom));
      drive();
      tick();
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (3) tick();

    // Reset during ACK aborts the acknowledge and clears the write.
    set_req(0, 2'd2, 8'h5A);
    pend[1] = 1'b0;
    drive();
    tick();
    check("abort_pre_ready", ready, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_regs", regs, 24'h0);
    model_reset();
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    set_req(0, 2'd1, 8'h77);
    set_req(1, 2'd1, 8'h88);
    drive();
    tick();
    check("abort_rr_zero", ready, 2'b01);
    repeat (3) tick();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (2) tick();

    // Mask write with reserved upper bits set, then watch the blink.
    set_req(0, 2'd3, 8'hC3);
    drive();
    tick();
    check("mask_ready", ready, 2'b01);
    repeat (14) tick();
    set_req(1, 2'd3, 8'hFF);
    drive();
    tick();
    check("mask2_ready", ready, 2'b10);
    repeat (10) tick();

    // Requester 1 alone and always valid: one grant every two cycles.
    g1_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (!pend[1]) set_req(1, 2'($urandom_range(0, 2)), 8'($urandom));
      drive();
      tick();
    end
    check("stream_grants", g1_cnt, 6);
    pend[1] = 1'b0;
    drive();
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) != 0)
          set_req(r, 2'($urandom_range(0, 3)), 8'($urandom));
      drive();
      tick();
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
